// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath widths and the queued command layout.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_NOT  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_AND  = 3'b011;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b100;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b101;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b110;
    localparam logic [OP_W-1:0] OP_ZERO = 3'b111;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue queue: circular storage with a registered occupancy count.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    input  logic     push,
    input  logic     pop,
    input  alu_cmd_t wr_data,
    output alu_cmd_t rd_data,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    alu_cmd_t mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage needs no reset: reads are only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue stage for the combinational ALU: buffers commands, presents the head to the ALU
// and captures the result into a valid/ready output slot with a completion counter.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [7:0]       alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic [2:0]       res_op,
    output logic             res_zero,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_t;

    slot_state_t state;
    alu_cmd_t    head;
    alu_cmd_t    wr_cmd;
    logic        full;
    logic        empty;
    logic        push;
    logic        issue;

    assign wr_cmd    = '{a: cmd_a, b: cmd_b, op: cmd_op};
    assign cmd_ready = !full;
    // A pop in the same cycle does not free a slot for a push when full.
    assign push      = cmd_valid && !full && !flush;
    assign issue     = !empty && ((state == SLOT_EMPTY) || res_ready) && !flush;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push    (push),
        .pop     (issue),
        .wr_data (wr_cmd),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign alu_a     = empty ? '0 : head.a;
    assign alu_b     = empty ? '0 : head.b;
    assign alu_op    = empty ? '0 : head.op;
    assign res_valid = (state == SLOT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SLOT_EMPTY;
            res_data   <= '0;
            res_op     <= '0;
            res_zero   <= 1'b0;
            done_count <= '0;
        end else if (flush) begin
            state <= SLOT_EMPTY;
        end else begin
            if (res_valid && res_ready) begin
                done_count <= done_count + CNT_W'(1);
            end
            case (state)
                SLOT_EMPTY: begin
                    if (issue) begin
                        res_data <= alu_out;
                        res_op   <= alu_op;
                        res_zero <= (alu_out == 8'h00);
                        state    <= SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (issue) begin
                        res_data <= alu_out;
                        res_op   <= alu_op;
                        res_zero <= (alu_out == 8'h00);
                    end else if (res_ready) begin
                        state <= SLOT_EMPTY;
                    end
                end
                default: state <= SLOT_EMPTY;
            endcase
        end
    end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
Upstream issue stage for the team's combinational 8-bit ALU (A, B, 3-bit opcode -> 8-bit out).
Accepts operand/opcode commands over a valid/ready handshake, buffers them in a small FIFO, presents the head entry to the ALU, and registers the ALU result into a valid/ready output slot with a zero flag and a completion counter.
Decouples the bursty command producer from the result consumer while the ALU stays purely combinational.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous flush of FIFO and result slot.
cmd_valid  input  1  command present.
cmd_ready  output  1  FIFO can accept a command.
cmd_a  input  8  operand A.
cmd_b  input  8  operand B.
cmd_op  input  3  ALU opcode.
alu_a  output  8  head-entry A to the ALU.
alu_b  output  8  head-entry B to the ALU.
alu_op  output  3  head-entry opcode to the ALU.
alu_out  input  8  combinational ALU result for alu_a/alu_b/alu_op.
res_valid  output  1  result slot holds a result.
res_ready  input  1  consumer takes the result.
res_data  output  8  registered ALU result.
res_op  output  3  opcode that produced res_data.
res_zero  output  1  res_data == 8'h00.
done_count  output  CNT_W  results handed to the consumer, modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, rd/wr pointers 0, res_valid 0, res_data 8'h00, res_op 3'b000, res_zero 0, done_count 0. Mid-operation reset discards all queued commands and any pending result.
- Outputs during reset and while FIFO empty: cmd_ready 1 once rst_n is high; alu_a/alu_b/alu_op 0 whenever the FIFO is empty.
- Push: cmd_valid && cmd_ready at an edge writes {cmd_a, cmd_b, cmd_op} at wr_ptr. cmd_ready = !full, a registered-count decode. No push while full even if a pop occurs in the same cycle.
- alu_a/alu_b/alu_op are driven combinationally from the FIFO head storage. The entry is visible the cycle after its push edge. There is no input-to-ALU bypass.
- Result slot FSM, two states:
  - EMPTY: res_valid 0.
  - FULL: res_valid 1.
- Issue condition: FIFO non-empty && (EMPTY || res_ready).
  - On issue at an edge: res_data <= alu_out, res_op <= alu_op, res_zero <= (alu_out == 0), head popped, slot becomes or stays FULL.
  - In FULL with res_ready && no issue: slot becomes EMPTY.
  - In FULL with !res_ready: res_data, res_op and res_zero hold stable.
- Latency: a command accepted at edge N appears at res_valid after edge N+1 when the slot is free. Sustained throughput is 1 result per cycle with res_ready held high.
- done_count increments by 1 on every edge with res_valid && res_ready. It wraps from all-ones to 0. flush does not clear it.
- Simultaneous push and pop on a non-full FIFO: both occur and the occupancy count is unchanged. Pointers wrap at DEPTH.
- flush (synchronous, highest priority over push, issue and consume):
  - Effect: FIFO empty, res_valid 0; a handshake in the flush cycle is not counted.
  - cmd_ready stays asserted during flush, but a command offered that cycle is dropped.
- Arithmetic: this block does no arithmetic on operands. The width of res_data is exactly the ALU's 8-bit out, so overflow and truncation are the ALU's.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_NOT=3'b000, OP_OR=3'b001, OP_XOR=3'b010, OP_AND=3'b011, OP_MUL=3'b100, OP_ADD=3'b101, OP_SUB=3'b110, OP_ZERO=3'b111;
  - DATA_W=8, OP_W=3;
  - a packed command struct {a, b, op}.
- One sub-module, alu_cmd_fifo: storage, pointers, count, full/empty.

Test Plan:
- Reset: drive rst_n low mid-burst with res_valid=1 -> res_valid 0, done_count 0, cmd_ready 1 immediately after release.
- Single op with the team ALU attached, res_ready=1: push A=8'h0F, B=8'h01, OP_ADD at edge N -> res_valid after edge N+1, res_data 8'h10, res_op 3'b101, res_zero 0, done_count 1 after the consume edge.
- Boundary results: OP_MUL 8'h10*8'h10 -> res_data 8'h00, res_zero 1. OP_SUB 8'h01-8'h02 -> res_data 8'hFF.
- Backpressure: res_ready=0, push 5 commands -> 1st in result slot, 4 in FIFO, cmd_ready 0 after the 5th accept. Raise res_ready -> results emerge in order, one per cycle, done_count 5.
- Simultaneous push/pop at 2 entries with res_ready=1 for 10 cycles -> occupancy stays 2, no loss or duplication, pointer wrap exercised.
- Flush with 3 queued and res_valid=1, res_ready=1 same cycle -> FIFO empty, res_valid 0, done_count unchanged.
